reram_xbar_seq: RTL and testbench
=================================

# reram_xbar_seq

Wishbone-controlled pulse sequencer that sits directly upstream of the ReRAM crossbar analog core inside the user analog project. It accepts SET/RESET/READ commands from the management SoC, drives one-hot row/column selects and a timed write/read enable into the crossbar, samples the crossbar sense comparator on READ, and reports completion through a status register and an interrupt.

## Interface
Parameters:
- ROWS, 4, crossbar rows; one-hot `row_sel` width (max 16)
- COLS, 4, crossbar columns; one-hot `col_sel` width (max 16)
- PW_W, 8, pulse-width counter width in bits

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  reset, synchronous, active-high
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic strobes
- wbs_sel_i  in  4  byte enables
- wbs_adr_i  in  32  address; only [3:2] decoded
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  single-cycle acknowledge
- wbs_dat_o  out  32  read data, valid with ack
- row_sel  out  ROWS  one-hot row select to crossbar
- col_sel  out  COLS  one-hot column select to crossbar
- set_en, reset_en, read_en  out  1 each  crossbar operation enables (at most one high)
- sense_i  in  1  asynchronous sense comparator output
- busy  out  1  operation in progress
- irq  out  1  level interrupt = done & irq_en

## Operation
- Registers, by adr[3:2]:
  - 0 CMD (W): [1:0] op (00 no-op, 01 SET, 10 RESET, 11 READ), [7:4] row, [11:8] col. Executes only when sel[0]=1 and the FSM is IDLE; writes while busy are acked and discarded. Reads return 0.
  - 1 PULSE (R/W, byte lanes honoured): [PW_W-1:0] pulse width in cycles, reset 10; value 0 behaves as 1.
  - 2 STATUS (R; W1C on bit 1): [0] busy, [1] done (sticky), [2] read_bit, [3] err (sticky, cleared with done).
  - 3 CTRL (R/W): [0] irq_en, reset 0.
- Bus: ack asserted one cycle after cyc&stb seen with ack low; ack deasserted the next cycle; exactly one ack per transfer, never back-to-back.
- sense_i passes through a two-flop synchronizer before use.
- FSM IDLE -> SETUP -> PULSE -> HOLD -> IDLE:
  - IDLE: selects and enables 0. A valid SET/RESET/READ CMD write latches op/row/col, clears done and err, goes to SETUP. A no-op write does nothing.
  - Out-of-range index (row >= ROWS or col >= COLS): no state change, selects untouched; done=1, err=1.
  - SETUP (1 cycle): row_sel/col_sel one-hot, enables 0; pulse counter loaded with max(PW,1).
  - PULSE (max(PW,1) cycles): selects held, the op's enable high. READ captures the synchronized sense into read_bit on the last PULSE cycle.
  - HOLD (1 cycle): enables 0, selects held. Then IDLE with done=1 and selects cleared.
- PULSE register writes during an operation take effect on the next command.
- A W1C done clear in the same cycle that HOLD sets done: set wins.
- Reset mid-operation: FSM to IDLE immediately; all enables and selects 0 on the next cycle.

## Timing
- Reset values: wbs_ack_o 0, wbs_dat_o 0, row_sel 0, col_sel 0, set_en/reset_en/read_en 0, busy 0, irq 0, PULSE 10, done/err/read_bit/irq_en 0.
- CMD accepted at edge E (the ack edge): busy high from E; SETUP during cycle E..E+1; enable high for max(PW,1) cycles starting E+1; HOLD one cycle; busy low and done high after max(PW,1)+2 cycles.
- irq follows done/irq_en combinationally from registers (no extra latency).
- read_bit reflects sense_i stable for at least 2 cycles before the last PULSE edge.

## Test plan
- Reset: assert wb_rst_i 2 cycles -> all outputs 0, STATUS reads 0x0, PULSE reads 10.
- SET row2 col1, PW=4: write CMD 0x0000_0121 -> row_sel=0100, col_sel=0010, set_en high exactly 4 cycles, busy high 6 cycles, STATUS=0x2.
- READ row3 col0, PW=0, sense_i=1 -> read_en high 1 cycle, STATUS=0x6; repeat with sense_i=0 -> STATUS=0x2.
- CMD row=5 on ROWS=4 -> no enable pulse, STATUS=0xA; write STATUS 0x2 -> STATUS=0x0.
- irq_en=1, RESET op, PW=3 -> irq rises with done; second CMD write while busy is acked and ignored (only one reset_en pulse).
- Reset asserted mid-PULSE of SET, PW=20 -> set_en and selects 0 the cycle after the reset edge, busy 0, PULSE returns to 10.

Source files
------------

// File: rtl/reram_xbar_seq_if.sv
// Wishbone classic slave bus bundle between the management SoC and the ReRAM pulse sequencer.
interface reram_xbar_seq_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/reram_xbar_seq.sv
// ReRAM crossbar pulse sequencer: Wishbone register file plus a SETUP/PULSE/HOLD FSM that
// drives one-hot selects, a timed SET/RESET/READ enable, and samples the sense comparator.
module reram_xbar_seq #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int PW_W = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  reram_xbar_seq_if.slave wbs,
  output logic [ROWS-1:0] row_sel,
  output logic [COLS-1:0] col_sel,
  output logic            set_en,
  output logic            reset_en,
  output logic            read_en,
  input  logic            sense_i,
  output logic            busy,
  output logic            irq
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD} state_t;

  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_RST  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  state_t r_state, w_state_nx;

  logic            r_ack;
  logic [31:0]     r_dat;
  logic [PW_W-1:0] r_pw;
  logic [PW_W-1:0] r_cnt;
  logic [1:0]      r_op;
  logic [3:0]      r_row, r_col;
  logic            r_done, r_err, r_rbit, r_irq_en;
  logic            r_sense_s1, r_sense_s2;

  logic            w_acc, w_wr;
  logic [1:0]      w_adr;
  logic            w_cmd_wr, w_oor, w_start, w_bad, w_last;
  logic [1:0]      w_op;
  logic [3:0]      w_row, w_col;
  logic [PW_W-1:0] w_pw1;
  logic [31:0]     w_rdata;

  // A transfer is taken on the edge that raises ack; ack low in between enforces spacing.
  assign w_acc    = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~r_ack;
  assign w_wr     = w_acc & wbs.wbs_we_i;
  assign w_adr    = wbs.wbs_adr_i[3:2];
  assign w_op     = wbs.wbs_dat_i[1:0];
  assign w_row    = wbs.wbs_dat_i[7:4];
  assign w_col    = wbs.wbs_dat_i[11:8];
  assign w_cmd_wr = w_wr && (w_adr == 2'd0) && wbs.wbs_sel_i[0] && (r_state == S_IDLE);
  assign w_oor    = (32'(w_row) >= ROWS) || (32'(w_col) >= COLS);
  assign w_start  = w_cmd_wr && (w_op != 2'b00) && !w_oor;
  assign w_bad    = w_cmd_wr && (w_op != 2'b00) && w_oor;
  assign w_pw1    = (r_pw == '0) ? PW_W'(1) : r_pw;
  assign w_last   = (r_state == S_PULSE) && (r_cnt == PW_W'(1));

  assign wbs.wbs_ack_o = r_ack;
  assign wbs.wbs_dat_o = r_dat;
  assign irq           = r_done & r_irq_en;

  always_comb begin
    w_rdata = '0;
    case (w_adr)
      2'd1:    w_rdata = 32'(r_pw);
      2'd2:    w_rdata = {28'd0, r_err, r_rbit, r_done, (r_state != S_IDLE)};
      2'd3:    w_rdata = {31'd0, r_irq_en};
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    row_sel    = '0;
    col_sel    = '0;
    set_en     = 1'b0;
    reset_en   = 1'b0;
    read_en    = 1'b0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (w_start) w_state_nx = S_SETUP;
      S_SETUP: w_state_nx = S_PULSE;
      S_PULSE: if (w_last) w_state_nx = S_HOLD;
      S_HOLD:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    if (r_state != S_IDLE) begin
      row_sel = ROWS'(1) << r_row;
      col_sel = COLS'(1) << r_col;
    end
    if (r_state == S_PULSE) begin
      set_en   = (r_op == OP_SET);
      reset_en = (r_op == OP_RST);
      read_en  = (r_op == OP_READ);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack      <= 1'b0;
      r_dat      <= '0;
      r_pw       <= PW_W'(10);
      r_cnt      <= '0;
      r_op       <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rbit     <= 1'b0;
      r_irq_en   <= 1'b0;
      r_sense_s1 <= 1'b0;
      r_sense_s2 <= 1'b0;
    end else begin
      r_ack      <= w_acc;
      r_dat      <= (w_acc && !wbs.wbs_we_i) ? w_rdata : '0;
      r_sense_s1 <= sense_i;
      r_sense_s2 <= r_sense_s1;

      // Pulse width is snapshotted into the counter at accept, so later PULSE writes wait a command.
      if (w_start) begin
        r_op  <= w_op;
        r_row <= w_row;
        r_col <= w_col;
        r_cnt <= w_pw1;
      end else if (r_state == S_PULSE) begin
        r_cnt <= r_cnt - PW_W'(1);
      end

      if (w_last && (r_op == OP_READ)) r_rbit <= r_sense_s2;

      // HOLD completion outranks a simultaneous W1C clear.
      if (w_start) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end else if (w_bad) begin
        r_done <= 1'b1;
        r_err  <= 1'b1;
      end else if (r_state == S_HOLD) begin
        r_done <= 1'b1;
      end else if (w_wr && (w_adr == 2'd2) && wbs.wbs_sel_i[0] && wbs.wbs_dat_i[1]) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end

      if (w_wr && (w_adr == 2'd1)) begin
        for (int i = 0; i < PW_W; i++)
          if (wbs.wbs_sel_i[i/8]) r_pw[i] <= wbs.wbs_dat_i[i];
      end

      if (w_wr && (w_adr == 2'd3) && wbs.wbs_sel_i[0]) r_irq_en <= wbs.wbs_dat_i[0];
    end
  end

endmodule

// File: tb/tb_reram_xbar_seq.sv
// Directed bench for reram_xbar_seq: register access, SET/RESET/READ pulse timing, errors, irq, reset.
module tb_reram_xbar_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reram_xbar_seq_if bus();
  logic [3:0] row_sel, col_sel;
  logic set_en, reset_en, read_en, sense, busy, irq;

  reram_xbar_seq #(.ROWS(4), .COLS(4), .PW_W(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs      (bus.slave),
    .row_sel  (row_sel),
    .col_sel  (col_sel),
    .set_en   (set_en),
    .reset_en (reset_en),
    .read_en  (read_en),
    .sense_i  (sense),
    .busy     (busy),
    .irq      (irq)
  );

  localparam logic [31:0] A_CMD = 32'h0, A_PW = 32'h4, A_ST = 32'h8, A_CTL = 32'hC;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Enable-cycle, pulse-count and busy-cycle monitor, sampled on the falling edge.
  int c_set = 0, c_rst = 0, c_rd = 0, c_busy = 0, p_set = 0, p_rst = 0, p_rd = 0;
  logic l_set = 1'b0, l_rst = 1'b0, l_rd = 1'b0;
  logic [3:0] m_row = '0, m_col = '0;
  always @(negedge clk) begin
    c_set  += int'(set_en);
    c_rst  += int'(reset_en);
    c_rd   += int'(read_en);
    c_busy += int'(busy);
    if (set_en && !l_set)   p_set++;
    if (reset_en && !l_rst) p_rst++;
    if (read_en && !l_rd)   p_rd++;
    l_set = set_en; l_rst = reset_en; l_rd = read_en;
    if (set_en || reset_en || read_en) begin
      m_row = row_sel;
      m_col = col_sel;
    end
  end

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd);
    int k;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;  bus.wbs_sel_i = sel;
    rd = '0;
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (!bus.wbs_ack_o && k < 20);
    if (!bus.wbs_ack_o) chk("ack_timeout", 32'd0, 32'd1);
    else rd = bus.wbs_dat_o;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
  endtask

  task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] d;
    wb_xfer(1'b1, adr, dat, sel, d);
  endtask

  task automatic wb_rd(input logic [31:0] adr, output logic [31:0] d);
    wb_xfer(1'b0, adr, 32'd0, 4'hF, d);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 200) begin @(negedge clk); k++; end
    if (busy) chk("idle_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    int s_set, s_rst, s_rd, s_busy, sp_set, sp_rst, sp_rd;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = '0;   bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;
    sense = 1'b0;

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_outs", {18'd0, bus.wbs_ack_o, (bus.wbs_dat_o != 0), row_sel, col_sel,
                     set_en, reset_en, read_en, busy, irq}, 32'd0);
    wb_rd(A_ST, d);  chk("rst_status", d, 32'h0);
    @(posedge clk); #1 chk("ack_single", {31'd0, bus.wbs_ack_o}, 32'd0);
    wb_rd(A_PW, d);  chk("rst_pulse", d, 32'd10);
    wb_rd(A_CTL, d); chk("rst_ctrl", d, 32'h0);

    // Byte lanes on PULSE, CMD ignored without sel[0], CMD reads 0
    wb_wr(A_PW, 32'h0000_0055, 4'b0010);
    wb_rd(A_PW, d);  chk("pw_lane", d, 32'd10);
    wb_wr(A_CMD, 32'h0000_0121, 4'b1110);
    #1 chk("cmd_nosel", {31'd0, busy}, 32'd0);
    wb_rd(A_CMD, d); chk("cmd_read0", d, 32'h0);

    // SET row2 col1, PW=4
    wb_wr(A_PW, 32'd4, 4'hF);
    s_set = c_set; s_busy = c_busy; sp_set = p_set;
    wb_wr(A_CMD, 32'h0000_0121, 4'hF);
    chk("set_busy_at_E", {31'd0, busy}, 32'd1);
    wait_idle();
    chk("set_en_cycles", c_set - s_set, 32'd4);
    chk("set_busy_cycles", c_busy - s_busy, 32'd6);
    chk("set_pulses", p_set - sp_set, 32'd1);
    chk("set_row", {28'd0, m_row}, 32'b0100);
    chk("set_col", {28'd0, m_col}, 32'b0010);
    chk("set_sel_clr", {24'd0, row_sel, col_sel}, 32'd0);
    wb_rd(A_ST, d);  chk("set_status", d, 32'h2);

    // READ row3 col0, PW=0, sense high then low
    wb_wr(A_PW, 32'd0, 4'hF);
    sense = 1'b1;
    repeat (3) @(posedge clk);
    #1 s_rd = c_rd;
    wb_wr(A_CMD, 32'h0000_0033, 4'hF);
    wait_idle();
    chk("rd1_cycles", c_rd - s_rd, 32'd1);
    chk("rd1_row", {28'd0, m_row}, 32'b1000);
    chk("rd1_col", {28'd0, m_col}, 32'b0001);
    wb_rd(A_ST, d);  chk("rd1_status", d, 32'h6);
    sense = 1'b0;
    repeat (3) @(posedge clk);
    #1 wb_wr(A_CMD, 32'h0000_0033, 4'hF);
    wait_idle();
    wb_rd(A_ST, d);  chk("rd0_status", d, 32'h2);

    // Out-of-range row, then column; W1C clears done and err
    s_set = c_set;
    wb_wr(A_CMD, 32'h0000_0051, 4'hF);
    #1 chk("oor_busy", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    chk("oor_no_pulse", c_set - s_set, 32'd0);
    wb_rd(A_ST, d);  chk("oor_status", d, 32'hA);
    wb_wr(A_ST, 32'h2, 4'hF);
    wb_rd(A_ST, d);  chk("w1c_status", d, 32'h0);
    wb_wr(A_CMD, 32'h0000_0401, 4'hF);
    wb_rd(A_ST, d);  chk("oor_col_status", d, 32'hA);

    // irq with RESET op, PW=3; second CMD while busy is dropped
    wb_wr(A_CTL, 32'h1, 4'hF);
    chk("irq_pre", {31'd0, irq}, 32'd1);
    wb_wr(A_PW, 32'd3, 4'hF);
    s_rst = c_rst; sp_rst = p_rst; sp_rd = p_rd;
    wb_wr(A_CMD, 32'h0000_0212, 4'hF);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    wb_wr(A_CMD, 32'h0000_0033, 4'hF);
    wait_idle();
    chk("rst_pulses", p_rst - sp_rst, 32'd1);
    chk("rst_cycles", c_rst - s_rst, 32'd3);
    chk("busy_cmd_dropped", p_rd - sp_rd, 32'd0);
    chk("irq_done", {31'd0, irq}, 32'd1);
    wb_rd(A_ST, d);  chk("rst_status", d, 32'h2);
    wb_wr(A_CTL, 32'h0, 4'hF);
    chk("irq_off", {31'd0, irq}, 32'd0);

    // Reset mid-PULSE of SET, PW=20
    wb_wr(A_PW, 32'd20, 4'hF);
    wb_wr(A_CMD, 32'h0000_0121, 4'hF);
    repeat (5) @(negedge clk);
    chk("mid_set_en", {31'd0, set_en}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_outs", {24'd0, row_sel, col_sel}, 32'd0);
    chk("mid_rst_en", {29'd0, set_en, reset_en, read_en}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    wb_rd(A_PW, d);  chk("mid_rst_pulse", d, 32'd10);
    wb_rd(A_ST, d);  chk("mid_rst_status", d, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
